// File: rtl/rotor3_fwd_stage_if.sv
// Letter stream channel used on both sides of the rotor 3 forward stage.
// The master drives valid/letter and the slave answers with ready.
interface rotor3_fwd_stage_if;
  logic       valid;
  logic       ready;
  logic [4:0] letter;

  modport master (
    output valid,
    output letter,
    input  ready
  );

  modport slave (
    input  valid,
    input  letter,
    output ready
  );
endinterface

// File: rtl/rotor3_fwd_stage.sv
// Rotor 3 forward pass: keeps the rotor position and carry, and encodes one letter per transfer.
// Defining ROTOR3_RINGSTELLUNG_EN adds a ring_set port that offsets the encode position.
module rotor3_fwd_stage #(
  parameter logic [4:0] NOTCH    = 5'd21,
  parameter logic [4:0] POS_INIT = 5'd0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      step_in,
  input  logic                      load_en,
  input  logic [4:0]                load_pos,
`ifdef ROTOR3_RINGSTELLUNG_EN
  input  logic [4:0]                ring_set,
`endif
  rotor3_fwd_stage_if.slave         in_if,
  rotor3_fwd_stage_if.master        out_if,
  output logic [4:0]                position,
  output logic                      carry_out
);

  // Operands never exceed 51, so one conditional subtraction is a full mod 26.
  function automatic logic [4:0] mod26(input logic [5:0] v);
    logic [5:0] r;
    r = (v >= 6'd26) ? (v - 6'd26) : v;
    return r[4:0];
  endfunction

  function automatic logic [4:0] wiring_f(input logic [4:0] letter);
    logic [4:0] c;
    case (letter)
      5'd1:    c = 5'd14;
      5'd2:    c = 5'd8;
      5'd3:    c = 5'd24;
      5'd4:    c = 5'd13;
      5'd5:    c = 5'd16;
      5'd6:    c = 5'd18;
      5'd7:    c = 5'd20;
      5'd8:    c = 5'd6;
      5'd9:    c = 5'd19;
      5'd10:   c = 5'd22;
      5'd11:   c = 5'd25;
      5'd12:   c = 5'd1;
      5'd13:   c = 5'd10;
      5'd14:   c = 5'd17;
      5'd15:   c = 5'd2;
      5'd16:   c = 5'd23;
      5'd17:   c = 5'd5;
      5'd18:   c = 5'd3;
      5'd19:   c = 5'd4;
      5'd20:   c = 5'd9;
      5'd21:   c = 5'd26;
      5'd22:   c = 5'd12;
      5'd23:   c = 5'd11;
      5'd24:   c = 5'd7;
      5'd25:   c = 5'd21;
      5'd26:   c = 5'd15;
      default: c = 5'd0;
    endcase
    return c;
  endfunction

  logic [4:0] pos_q, pos_d;
  logic       carry_q, carry_d;
  logic       out_valid_q, out_valid_d;
  logic [4:0] out_letter_q, out_letter_d;
  logic       rdy_q, rdy_d;

  logic       in_ready;
  logic       accept;
  logic       letter_ok;
  logic [4:0] contact;
  logic [4:0] p_eff;
  logic [5:0] sum;
  logic [4:0] sum_mod;
  logic [4:0] enc_letter;

  // Load beats step; carry only pulses when stepping off the notch.
  always_comb begin
    pos_d   = pos_q;
    carry_d = 1'b0;
    if (load_en) begin
      pos_d = mod26({1'b0, load_pos});
    end else if (step_in) begin
      pos_d   = (pos_q == 5'd25) ? 5'd0 : (pos_q + 5'd1);
      carry_d = (pos_q == NOTCH);
    end
  end

  // Encoding uses the post-step position of the same cycle.
  always_comb begin
    p_eff = pos_d;
`ifdef ROTOR3_RINGSTELLUNG_EN
    p_eff = mod26({1'b0, pos_d} + 6'd26 - {1'b0, mod26({1'b0, ring_set})});
`endif
    letter_ok  = (in_if.letter >= 5'd1) && (in_if.letter <= 5'd26);
    contact    = wiring_f(in_if.letter);
    sum        = {1'b0, contact} + {1'b0, p_eff};
    sum_mod    = mod26(sum);
    enc_letter = 5'd0;
    if (letter_ok) begin
      enc_letter = (sum_mod == 5'd0) ? 5'd26 : sum_mod;
    end
  end

  // rdy_q keeps the stage closed for the first cycle out of reset.
  always_comb begin
    in_ready     = rdy_q & (~out_valid_q | out_if.ready);
    accept       = in_if.valid & in_ready;
    rdy_d        = 1'b1;
    out_valid_d  = out_valid_q;
    out_letter_d = out_letter_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_letter_d = enc_letter;
    end else if (out_if.ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q        <= POS_INIT;
      carry_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_letter_q <= 5'd0;
      rdy_q        <= 1'b0;
    end else begin
      pos_q        <= pos_d;
      carry_q      <= carry_d;
      out_valid_q  <= out_valid_d;
      out_letter_q <= out_letter_d;
      rdy_q        <= rdy_d;
    end
  end

  assign in_if.ready   = in_ready;
  assign out_if.valid  = out_valid_q;
  assign out_if.letter = out_letter_q;
  assign position      = pos_q;
  assign carry_out     = carry_q;

endmodule

// File: tb/tb_rotor3_fwd_stage.sv
// Scoreboard bench for rotor3_fwd_stage: directed vectors plus a round-trip sweep.
module tb_rotor3_fwd_stage;

  typedef struct {
    logic [4:0] exp;
    bit         rt;
    logic [4:0] pos;
    logic [4:0] letter;
  } sbEntry_t;

  logic       clk;
  logic       rst_n;
  logic       step_in;
  logic       load_en;
  logic [4:0] load_pos;
  logic [4:0] position;
  logic       carry_out;
`ifdef ROTOR3_RINGSTELLUNG_EN
  logic [4:0] ringSet;
`endif

  rotor3_fwd_stage_if in_if ();
  rotor3_fwd_stage_if out_if ();

  rotor3_fwd_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .step_in   (step_in),
    .load_en   (load_en),
    .load_pos  (load_pos),
`ifdef ROTOR3_RINGSTELLUNG_EN
    .ring_set  (ringSet),
`endif
    .in_if     (in_if),
    .out_if    (out_if),
    .position  (position),
    .carry_out (carry_out)
  );

  int fwdMap[27] = '{0, 14, 8, 24, 13, 16, 18, 20, 6, 19, 22, 25, 1, 10,
                     17, 2, 23, 5, 3, 4, 9, 26, 12, 11, 7, 21, 15};
  int invMap[27];
  sbEntry_t sb[$];
  int total = 0;
  int bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Starts and ends just after a rising edge; retries while the stage is not ready.
  task automatic applyStimulus(input logic [4:0] letter, input logic step, input logic [4:0] exp,
                               input bit rt, input logic [4:0] rtPos, input bit immediate);
    bit done;
    sbEntry_t e;
    done = 0;
    in_if.valid  = 1'b1;
    in_if.letter = letter;
    step_in      = step;
    for (int tries = 0; tries < 20 && !done; tries++) begin
      @(negedge clk);
      if (immediate && tries == 0) checkOutput("in_ready_tput", int'(in_if.ready), 1);
      if (in_if.ready) begin
        e.exp = exp; e.rt = rt; e.pos = rtPos; e.letter = letter;
        sb.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
      step_in = 1'b0;
    end
    in_if.valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("[TB] FAIL accept_timeout actual=not_accepted expected=accepted letter=%0d", letter);
    end
  endtask

  task automatic ctrlCycle(input logic ld, input logic [4:0] ldPos, input logic st);
    load_en  = ld;
    load_pos = ldPos;
    step_in  = st;
    @(negedge clk);
    @(posedge clk); #1;
    load_en = 1'b0;
    step_in = 1'b0;
  endtask

  task automatic checkCtrl(input string name, input int expPos, input int expCarry);
    @(negedge clk);
    checkOutput({name, "_pos"}, int'(position), expPos);
    checkOutput({name, "_carry"}, int'(carry_out), expCarry);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 50 && sb.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("[TB] FAIL drain_timeout actual=%0d_pending expected=0_pending", sb.size());
    end
  endtask

  // Monitor: every presented-and-taken output pops one scoreboard entry.
  initial begin
    sbEntry_t e;
    int c;
    int rtLetter;
    forever begin
      @(negedge clk);
      if (rst_n && out_if.valid && out_if.ready) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL unexpected_output actual=%0d expected=none", out_if.letter);
        end else begin
          e = sb.pop_front();
          if (e.rt) begin
            rtLetter = 0;
            if (out_if.letter >= 5'd1 && out_if.letter <= 5'd26) begin
              c = int'(out_if.letter) - int'(e.pos);
              if (c <= 0) c += 26;
              rtLetter = invMap[c];
            end
            checkOutput("roundtrip", rtLetter, int'(e.letter));
          end else begin
            checkOutput("out_letter", int'(out_if.letter), int'(e.exp));
          end
        end
      end
    end
  end

  initial begin
    int p;
    int l;
    for (int i = 1; i <= 26; i++) invMap[fwdMap[i]] = i;
    rst_n        = 1'b0;
    step_in      = 1'b0;
    load_en      = 1'b0;
    load_pos     = 5'd0;
    in_if.valid  = 1'b0;
    in_if.letter = 5'd0;
    out_if.ready = 1'b1;
`ifdef ROTOR3_RINGSTELLUNG_EN
    ringSet = 5'd0;
`endif

    // Reset state and delayed in_ready
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_position", int'(position), 0);
    checkOutput("rst_out_valid", int'(out_if.valid), 0);
    checkOutput("rst_out_letter", int'(out_if.letter), 0);
    checkOutput("rst_carry", int'(carry_out), 0);
    checkOutput("rst_in_ready", int'(in_if.ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("in_ready_delay", int'(in_if.ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("in_ready_up", int'(in_if.ready), 1);
    @(posedge clk); #1;

    // Basic encode, then step-before-encode
    applyStimulus(5'd1, 1'b0, 5'd14, 0, 5'd0, 1);
    ctrlCycle(1'b1, 5'd3, 1'b0);
    applyStimulus(5'd3, 1'b1, 5'd2, 0, 5'd0, 1);
    checkCtrl("step_encode", 4, 0);

    // Notch carry and wrap
    ctrlCycle(1'b1, 5'd21, 1'b0);
    checkCtrl("load21", 21, 0);
    ctrlCycle(1'b0, 5'd0, 1'b1);
    checkCtrl("notch_step", 22, 1);
    checkCtrl("carry_pulse_end", 22, 0);
    ctrlCycle(1'b1, 5'd25, 1'b0);
    ctrlCycle(1'b0, 5'd0, 1'b1);
    checkCtrl("wrap_step", 0, 0);

    // Backpressure: hold, step while held, then full throughput
    out_if.ready = 1'b0;
    applyStimulus(5'd1, 1'b0, 5'd14, 0, 5'd0, 1);
    in_if.valid  = 1'b1;
    in_if.letter = 5'd2;
    step_in      = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("hold_in_ready", int'(in_if.ready), 0);
      checkOutput("hold_out_valid", int'(out_if.valid), 1);
      checkOutput("hold_out_letter", int'(out_if.letter), 14);
      @(posedge clk); #1;
      step_in = 1'b0;
    end
    out_if.ready = 1'b1;
    applyStimulus(5'd2, 1'b0, 5'd9, 0, 5'd0, 1);
    applyStimulus(5'd3, 1'b0, 5'd25, 0, 5'd0, 1);
    applyStimulus(5'd4, 1'b0, 5'd14, 0, 5'd0, 1);
    applyStimulus(5'd5, 1'b0, 5'd17, 0, 5'd0, 1);

    // Invalid letters, load priority, load modulo and wrap-to-26 encode
    applyStimulus(5'd0, 1'b0, 5'd0, 0, 5'd0, 1);
    applyStimulus(5'd27, 1'b0, 5'd0, 0, 5'd0, 1);
    ctrlCycle(1'b1, 5'd21, 1'b0);
    ctrlCycle(1'b1, 5'd21, 1'b1);
    checkCtrl("load_beats_step", 21, 0);
    ctrlCycle(1'b1, 5'd28, 1'b0);
    checkCtrl("load_mod26", 2, 0);
    applyStimulus(5'd24, 1'b0, 5'd9, 0, 5'd0, 1);
    applyStimulus(5'd21, 1'b0, 5'd2, 0, 5'd0, 1);
    applyStimulus(5'd3, 1'b0, 5'd26, 0, 5'd0, 1);
    applyStimulus(5'd20, 1'b0, 5'd11, 0, 5'd0, 1);

    // Round-trip sweep through the inverse wiring
    for (int k = 0; k < 12; k++) begin
      p = int'($urandom_range(0, 25));
      l = int'($urandom_range(1, 26));
      if ((fwdMap[l] + p) % 26 == 0) continue;
      ctrlCycle(1'b1, 5'(p), 1'b0);
      applyStimulus(5'(l), 1'b0, 5'd0, 1, 5'(p), 1);
    end
    drain();

    // Reset while a letter is held
    out_if.ready = 1'b0;
    applyStimulus(5'd7, 1'b0, 5'd0, 0, 5'd0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_out_valid", int'(out_if.valid), 0);
    checkOutput("midrst_out_letter", int'(out_if.letter), 0);
    checkOutput("midrst_position", int'(position), 0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_if.ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkOutput("post_rst_no_valid", int'(out_if.valid), 0);
      @(posedge clk); #1;
    end
    applyStimulus(5'd1, 1'b0, 5'd14, 0, 5'd0, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
